dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the backing store; power of two.
REQ-002 Parameter LATENCY, default 2, range 0..15: wait-state cycles inserted between request acceptance and response.
REQ-003 CLK  input  1: single clock; all state updates on rising edge.
REQ-004 RST  input  1: reset, synchronous and active-high.
REQ-005 Req_Valid  input  1: requester presents a load/store request.
REQ-006 Req_Ready  output  1: responder accepts the request this cycle.
REQ-007 Req_W_En  input  1: 1 = store, 0 = load.
REQ-008 Req_Control  input  3: funct3 access type (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 Req_Addr  input  32: byte address.
REQ-010 Req_W_Data  input  32: store data, right-aligned.
REQ-011 Rsp_Valid  output  1: response available.
REQ-012 Rsp_Ready  input  1: requester consumes the response.
REQ-013 Rsp_Data  output  32: extended load data; 0 for stores and errors.
REQ-014 Rsp_Err  output  1: access faulted; qualified by Rsp_Valid.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, WAIT, RESP.
REQ-016 Req_Ready SHALL be 1 only in IDLE; a request is accepted on an edge where Req_Valid and Req_Ready are both 1.
REQ-017 On acceptance, the block SHALL register Req_W_En, Req_Control, Req_Addr and Req_W_Data, then go to WAIT if LATENCY>0, else to RESP.
REQ-018 In WAIT, a 4-bit counter SHALL count LATENCY cycles; when it expires, the FSM moves to RESP.
REQ-019 Rsp_Valid SHALL rise exactly LATENCY+1 cycles after the accepting edge.
REQ-020 Rsp_Valid, Rsp_Data and Rsp_Err SHALL stay stable in RESP until an edge where Rsp_Ready=1; the FSM then returns to IDLE.
REQ-021 Back-to-back requests are allowed: a new request can be accepted in the cycle immediately after the RESP handshake.
REQ-022 The word index SHALL be Req_Addr[log2(DEPTH_WORDS)+1:2]; the byte lane is Req_Addr[1:0].
REQ-023 Error conditions: Req_Addr >= 4*DEPTH_WORDS; halfword access with Addr[0]=1; word access with Addr[1:0]!=0; Req_Control not in {000,001,010,100,101}; a store with Req_Control 100 or 101.
REQ-024 An errored access SHALL respond with Rsp_Err=1 and Rsp_Data=0, and SHALL NOT modify the store.
REQ-025 Stores SHALL write only the addressed byte lanes (SB: 1 lane, SH: 2 lanes, SW: 4 lanes).
REQ-026 The store write SHALL occur on the edge that enters RESP, exactly once per request.
REQ-027 Loads SHALL read the word on the edge that enters RESP, then select the addressed lane(s).
REQ-028 Load extension: LB and LH sign-extend; LBU and LHU zero-extend; LW returns the full word.
REQ-029 A load issued after a store to the same address SHALL return the newly stored data.
REQ-030 Req_* inputs SHALL be ignored outside IDLE.
REQ-031 Rsp_Ready SHALL be ignored outside RESP.

Reset
REQ-032 While RST=1 at an edge, the block SHALL set: FSM to IDLE, counter to 0, Rsp_Valid=0, Rsp_Data=0, Rsp_Err=0; Req_Ready=1 in the following cycle.
REQ-033 Reset during WAIT SHALL drop the pending request; no store write occurs and no response is produced.
REQ-034 Reset during RESP SHALL drop the response; a write already performed is retained.
REQ-035 Backing-store contents SHALL NOT be cleared by reset.

Verification
REQ-036 LATENCY=2: SW 0xDEADBEEF to 0x10, then LW 0x10 -> Rsp_Valid rises 3 cycles after each accept; Rsp_Data=0xDEADBEEF, Rsp_Err=0.
REQ-037 SB 0x80 to 0x13, then LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
REQ-038 LH 0x11 and SW 0x12 -> Rsp_Err=1, Rsp_Data=0; a following LW 0x10 shows unchanged data.
REQ-039 Hold Rsp_Ready=0 for 5 cycles in RESP -> outputs stable and Req_Ready=0 throughout; on release, Req_Ready=1 on the next cycle.
REQ-040 SW 0x12345678 to 0x20, RST asserted one cycle after accept -> Rsp_Valid never rises; LW 0x20 returns the prior contents.
REQ-041 LATENCY=0: LW accepted -> Rsp_Valid=1 on the next cycle; address 4*DEPTH_WORDS -> Rsp_Err=1.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed wait states,
// RISC-V load/store lane handling with fault reporting.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_W_En,
  input  logic [2:0]  Req_Control,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_W_Data,
  output logic        Rsp_Valid,
  input  logic        Rsp_Ready,
  output logic [31:0] Rsp_Data,
  output logic        Rsp_Err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAST = 4'(LATENCY > 0 ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        r_we;
  logic [2:0]  r_ctl;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic [31:0] mem [DEPTH_WORDS];

  logic          idle;
  logic          enter;
  logic          a_we;
  logic [2:0]    a_ctl;
  logic [31:0]   a_addr;
  logic [31:0]   a_wdata;
  logic [1:0]    lane;
  logic [AW-1:0] idx;
  logic          oob;
  logic          bad_ctl;
  logic          misal;
  logic          err;
  logic [3:0]    wmask;
  logic [31:0]   wword;
  logic          do_write;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   ld;
  logic [31:0]   rsp_next;

  assign idle      = (state == IDLE);
  assign Req_Ready = idle;

  // With zero latency the access happens on the accepting edge,
  // so the live request is used instead of the registered copy.
  assign a_we    = idle ? Req_W_En    : r_we;
  assign a_ctl   = idle ? Req_Control : r_ctl;
  assign a_addr  = idle ? Req_Addr    : r_addr;
  assign a_wdata = idle ? Req_W_Data  : r_wdata;

  assign enter = idle ? (Req_Valid && (LATENCY == 0))
                      : ((state == WAIT) && (cnt == LAST));

  assign lane = a_addr[1:0];
  assign idx  = a_addr[AW+1:2];
  assign oob  = (a_addr >> (AW + 2)) != 32'd0;

  always_comb begin
    bad_ctl = 1'b0;
    misal   = 1'b0;
    case (a_ctl)
      3'b000, 3'b100: misal = 1'b0;
      3'b001, 3'b101: misal = lane[0];
      3'b010:         misal = |lane;
      default:        bad_ctl = 1'b1;
    endcase
  end

  assign err = oob | bad_ctl | misal | (a_we & a_ctl[2]);

  always_comb begin
    wmask = 4'b1111;
    wword = a_wdata;
    case (a_ctl[1:0])
      2'b00: begin
        wmask = 4'b0001 << lane;
        wword = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        wmask = 4'b0011 << lane;
        wword = {2{a_wdata[15:0]}};
      end
      default: begin
        wmask = 4'b1111;
        wword = a_wdata;
      end
    endcase
  end

  assign do_write = enter & a_we & ~err & ~RST;

  always_ff @(posedge CLK) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign rword = mem[idx];

  always_comb begin
    rbyte = rword[7:0];
    case (lane)
      2'd0: rbyte = rword[7:0];
      2'd1: rbyte = rword[15:8];
      2'd2: rbyte = rword[23:16];
      2'd3: rbyte = rword[31:24];
      default: rbyte = rword[7:0];
    endcase
    rhalf = lane[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    ld = rword;
    case (a_ctl)
      3'b000:  ld = {{24{rbyte[7]}}, rbyte};
      3'b100:  ld = {24'd0, rbyte};
      3'b001:  ld = {{16{rhalf[15]}}, rhalf};
      3'b101:  ld = {16'd0, rhalf};
      default: ld = rword;
    endcase
  end

  assign rsp_next = (a_we | err) ? 32'd0 : ld;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      Rsp_Valid <= 1'b0;
      Rsp_Data  <= 32'd0;
      Rsp_Err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Req_Valid) begin
            r_we    <= Req_W_En;
            r_ctl   <= Req_Control;
            r_addr  <= Req_Addr;
            r_wdata <= Req_W_Data;
            cnt     <= 4'd0;
            if (enter) begin
              state     <= RESP;
              Rsp_Valid <= 1'b1;
              Rsp_Data  <= rsp_next;
              Rsp_Err   <= err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (enter) begin
            state     <= RESP;
            Rsp_Valid <= 1'b1;
            Rsp_Data  <= rsp_next;
            Rsp_Err   <= err;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: begin
          if (Rsp_Ready) begin
            state     <= IDLE;
            Rsp_Valid <= 1'b0;
            Rsp_Data  <= 32'd0;
            Rsp_Err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
